evn_seq: RTL and testbench
==========================

EVN_SEQ -- requirements
Module: evn_seq

Interface
REQ-001 Parameter CW, default 32, width of the interval, timeout and repeat counters.
REQ-002 Parameter TN, default 1, number of trigger inputs.
REQ-003 clk  input  1  single clock; every register is in this domain.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ctl_str / ctl_stp / ctl_rst  input  1 each  software start / stop / reset pulses, one cycle wide.
REQ-006 cfg_pre  input  CW  pre-trigger interval, in cycles.
REQ-007 cfg_pst  input  CW  post-trigger interval, in cycles.
REQ-008 cfg_rpt  input  CW  acquisition count; 0 means run until stopped.
REQ-009 cfg_trg  input  TN  trigger source mask.
REQ-010 cfg_tmo  input  CW  arm timeout, in cycles; 0 disables the timeout.
REQ-011 trg  input  TN  trigger inputs, level-sensitive.
REQ-012 evo  output  evn_pkg::evn_t  registered rst/str/stp/swt event pulses driving downstream acquisition units.
REQ-013 sts_st  output  evn_pkg::seq_st_t  current state.
REQ-014 sts_rpt  output  CW  number of completed acquisitions.
REQ-015 sts_tmo  output  1  sticky flag: a timeout forced the trigger.
REQ-016 irq  output  1  one-cycle pulse when the sequence completes.

Function
REQ-017 The state machine SHALL have the states IDLE, PRE, ARM and POST.
REQ-018 IDLE->PRE SHALL occur on ctl_str, latching cfg_pre/cfg_pst/cfg_rpt/cfg_trg/cfg_tmo, clearing sts_rpt and sts_tmo, and pulsing evo.str.
REQ-019 PRE SHALL last max(cfg_pre,1) cycles and then go to ARM; triggers SHALL be ignored in PRE.
REQ-020 ARM->POST SHALL occur on the first cycle where |(trg & cfg_trg) is 1, pulsing evo.swt.
REQ-021 POST SHALL last max(cfg_pst,1) cycles; on exit it SHALL increment sts_rpt and pulse evo.stp.
REQ-022 On POST exit, if cfg_rpt==0 or sts_rpt+1<cfg_rpt, the next state SHALL be PRE and evo.str SHALL pulse in the same cycle as evo.stp; otherwise the next state SHALL be IDLE and irq SHALL pulse.
REQ-023 ctl_stp in PRE/ARM/POST SHALL force IDLE, pulse evo.stp and leave sts_rpt unchanged; irq SHALL NOT pulse.
REQ-024 ctl_rst in any state SHALL force IDLE, pulse evo.rst only (no other evo bits), and clear sts_rpt and sts_tmo.
REQ-025 Priority for simultaneous inputs SHALL be ctl_rst > ctl_stp > ctl_str > internal transitions; ctl_str outside IDLE SHALL be ignored.
REQ-026 Every evo bit SHALL be registered and appear exactly 1 cycle after the causing input or transition; outside those cycles evo SHALL be 0.
REQ-027 sts_rpt SHALL saturate at 2^CW-1; the interval counter SHALL reload on every state entry.
REQ-028 Configuration inputs SHALL be sampled only on IDLE->PRE; changes during a sequence SHALL take no effect.

Reset
REQ-029 While rst is high: state=IDLE, evo=0, sts_rpt=0, sts_tmo=0, irq=0, and all latched configuration =0.
REQ-030 Reset asserted mid-sequence SHALL abort immediately with no event pulse.

Configuration
REQ-031 With macro EVN_SEQ_TIMEOUT_EN defined: in ARM, after cfg_tmo cycles with cfg_tmo!=0 and no trigger, the block SHALL take the ARM->POST transition as if triggered, pulse evo.swt and set sts_tmo.
REQ-032 Without EVN_SEQ_TIMEOUT_EN: cfg_tmo SHALL be ignored, sts_tmo SHALL be tied to 0, and no timeout counter SHALL be synthesized.

Structure
REQ-033 The existing evn_pkg SHALL receive typedef seq_st_t (enum of 4 states, 2 bits); evn_t is reused unchanged.
REQ-034 The block SHALL have no sub-module; the interval and timeout counters SHALL be inline.

Verification
REQ-035 cfg_pre=3, cfg_pst=2, cfg_rpt=1, trg at ARM cycle 5 -> evo.str at T+1, swt 1 cycle after the trigger, stp and irq 2 cycles later, sts_rpt=1, state=IDLE.
REQ-036 cfg_rpt=3, periodic trigger -> three str/swt/stp triplets with back-to-back stp+str in the same cycle twice, irq once, sts_rpt=3.
REQ-037 cfg_rpt=0, ctl_stp during ARM -> evo.stp only, IDLE, no irq, sts_rpt holds the prior count.
REQ-038 ctl_rst+ctl_stp+ctl_str in the same cycle while in POST -> evo=rst only, IDLE, sts_rpt=0.
REQ-039 Trigger held high during PRE with cfg_pre=4 -> no swt until the first ARM cycle; cfg_pre=0 behaves as cfg_pre=1.
REQ-040 With EVN_SEQ_TIMEOUT_EN defined, cfg_tmo=10 and no trigger -> swt after 10 ARM cycles and sts_tmo=1; without the macro, the block remains in ARM indefinitely.

Source files
------------

// File: rtl/evn_pkg.sv
// Shared event-sequencing types: the downstream event pulse bundle and the
// sequencer state encoding.
package evn_pkg;

    typedef struct packed {
        logic rst;
        logic str;
        logic stp;
        logic swt;
    } evn_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ARM  = 2'd2,
        ST_POST = 2'd3
    } seq_st_t;

endpackage

// File: rtl/evn_seq.sv
// Acquisition event sequencer: IDLE -> PRE -> ARM -> POST with repeat count.
// Optional arm timeout is built only when EVN_SEQ_TIMEOUT_EN is defined.
module evn_seq
    import evn_pkg::*;
#(
    parameter int CW = 32,
    parameter int TN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctl_str,
    input  logic           ctl_stp,
    input  logic           ctl_rst,
    input  logic [CW-1:0]  cfg_pre,
    input  logic [CW-1:0]  cfg_pst,
    input  logic [CW-1:0]  cfg_rpt,
    input  logic [TN-1:0]  cfg_trg,
    input  logic [CW-1:0]  cfg_tmo,
    input  logic [TN-1:0]  trg,
    output evn_pkg::evn_t  evo,
    output evn_pkg::seq_st_t sts_st,
    output logic [CW-1:0]  sts_rpt,
    output logic           sts_tmo,
    output logic           irq
);

    localparam logic [CW-1:0] ONE = CW'(1);

    seq_st_t       st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] pre_q;
    logic [CW-1:0] pst_q;
    logic [CW-1:0] rpt_q;
    logic [TN-1:0] trg_q;

    logic          hit;
    logic          tmo_fire;
    logic          more;
    logic [CW:0]   rpt_nxt;
    logic [CW-1:0] rpt_inc;

    // A zero-length interval still spends one cycle in its state.
    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign hit     = |(trg & trg_q);
    assign rpt_nxt = {1'b0, sts_rpt} + {{CW{1'b0}}, 1'b1};
    assign more    = (rpt_q == '0) || (rpt_nxt < {1'b0, rpt_q});
    assign rpt_inc = (&sts_rpt) ? sts_rpt : rpt_nxt[CW-1:0];
    assign sts_st  = st;

`ifdef EVN_SEQ_TIMEOUT_EN
    logic [CW-1:0] tmo_q;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_flag;

    // tmo_cnt holds the 1-based index of the current ARM cycle.
    assign tmo_fire = (tmo_q != '0) && (tmo_cnt == tmo_q);
    assign sts_tmo  = tmo_flag;
`else
    logic unused_tmo;

    assign unused_tmo = ^cfg_tmo;
    assign tmo_fire   = 1'b0;
    assign sts_tmo    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_IDLE;
            cnt     <= '0;
            pre_q   <= '0;
            pst_q   <= '0;
            rpt_q   <= '0;
            trg_q   <= '0;
            evo     <= '0;
            sts_rpt <= '0;
            irq     <= 1'b0;
`ifdef EVN_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
`endif
        end else begin
            evo <= '0;
            irq <= 1'b0;
            if (ctl_rst) begin
                st      <= ST_IDLE;
                evo.rst <= 1'b1;
                sts_rpt <= '0;
`ifdef EVN_SEQ_TIMEOUT_EN
                tmo_flag <= 1'b0;
`endif
            end else if (ctl_stp) begin
                if (st != ST_IDLE) begin
                    st      <= ST_IDLE;
                    evo.stp <= 1'b1;
                end
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (ctl_str) begin
                            pre_q   <= cfg_pre;
                            pst_q   <= cfg_pst;
                            rpt_q   <= cfg_rpt;
                            trg_q   <= cfg_trg;
                            cnt     <= at_least_one(cfg_pre);
                            sts_rpt <= '0;
                            evo.str <= 1'b1;
                            st      <= ST_PRE;
`ifdef EVN_SEQ_TIMEOUT_EN
                            tmo_q    <= cfg_tmo;
                            tmo_flag <= 1'b0;
`endif
                        end
                    end
                    ST_PRE: begin
                        if (cnt <= ONE) begin
                            st <= ST_ARM;
`ifdef EVN_SEQ_TIMEOUT_EN
                            tmo_cnt <= ONE;
`endif
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    ST_ARM: begin
                        if (hit || tmo_fire) begin
                            st      <= ST_POST;
                            cnt     <= at_least_one(pst_q);
                            evo.swt <= 1'b1;
`ifdef EVN_SEQ_TIMEOUT_EN
                            if (!hit) tmo_flag <= 1'b1;
`endif
                        end
`ifdef EVN_SEQ_TIMEOUT_EN
                        else begin
                            tmo_cnt <= tmo_cnt + ONE;
                        end
`endif
                    end
                    ST_POST: begin
                        if (cnt <= ONE) begin
                            sts_rpt <= rpt_inc;
                            evo.stp <= 1'b1;
                            if (more) begin
                                st      <= ST_PRE;
                                cnt     <= at_least_one(pre_q);
                                evo.str <= 1'b1;
                            end else begin
                                st  <= ST_IDLE;
                                irq <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_evn_seq.sv
// Directed bench for evn_seq (CW=4 to reach repeat-count saturation quickly,
// TN=2 to exercise the trigger mask).
module tb_evn_seq;
    import evn_pkg::*;

    localparam int CW = 4;
    localparam int TN = 2;

    localparam logic [4:0] EV_SWT = 5'b00001;
    localparam logic [4:0] EV_STP = 5'b00010;
    localparam logic [4:0] EV_STR = 5'b00100;
    localparam logic [4:0] EV_RST = 5'b01000;
    localparam logic [4:0] EV_IRQ = 5'b10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_str, ctl_stp, ctl_rst;
    logic [CW-1:0] cfg_pre, cfg_pst, cfg_rpt, cfg_tmo;
    logic [TN-1:0] cfg_trg, trg;
    evn_t          evo;
    seq_st_t       sts_st;
    logic [CW-1:0] sts_rpt;
    logic          sts_tmo;
    logic          irq;

    int n_chk = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    evn_seq #(.CW(CW), .TN(TN)) dut (
        .clk(clk), .rst(rst),
        .ctl_str(ctl_str), .ctl_stp(ctl_stp), .ctl_rst(ctl_rst),
        .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .cfg_rpt(cfg_rpt),
        .cfg_trg(cfg_trg), .cfg_tmo(cfg_tmo), .trg(trg),
        .evo(evo), .sts_st(sts_st), .sts_rpt(sts_rpt),
        .sts_tmo(sts_tmo), .irq(irq)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every non-zero {irq, evo} cycle must match the next expected event
    always @(negedge clk) begin
        logic [4:0] ev;
        logic [4:0] want;
        ev = {irq, evo};
        if (!rst && ev != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexp", 32'(ev), 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("sb_event", 32'(ev), 32'(want));
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [CW-1:0] pre, input logic [CW-1:0] pst,
                         input logic [CW-1:0] rpt, input logic [CW-1:0] tmo,
                         input logic [TN-1:0] msk);
        cfg_pre = pre; cfg_pst = pst; cfg_rpt = rpt; cfg_tmo = tmo; cfg_trg = msk;
        ctl_str = 1'b1;
        step(1);
        ctl_str = 1'b0;
    endtask

    task automatic pulse_stp();
        ctl_stp = 1'b1;
        step(1);
        ctl_stp = 1'b0;
    endtask

    task automatic wait_st(input seq_st_t s, input int budget, input string tag);
        int n;
        n = 0;
        while (sts_st != s && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(sts_st), 32'(s));
    endtask

    task automatic wait_stp(input int target, input int budget, input string tag);
        int n, seen;
        n = 0;
        seen = 0;
        while (seen < target && n < budget) begin
            step(1);
            n++;
            if (evo.stp) seen++;
        end
        check(tag, 32'(seen), 32'(target));
    endtask

    initial begin
        int n_bb, n;
        rst = 1'b1;
        ctl_str = 1'b0; ctl_stp = 1'b0; ctl_rst = 1'b0;
        cfg_pre = '0; cfg_pst = '0; cfg_rpt = '0; cfg_tmo = '0; cfg_trg = '0;
        trg = '0;
        step(2);
        check("rst_st", 32'(sts_st), 32'(ST_IDLE));
        check("rst_evo", 32'(evo), 32'd0);
        check("rst_rpt", 32'(sts_rpt), 32'd0);
        check("rst_tmo", 32'(sts_tmo), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        step(2);

        // single acquisition, exact cycle timing
        exp_q.push_back(EV_STR); exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_IRQ);
        start(4'd3, 4'd2, 4'd1, 4'd0, 2'b01);
        check("t1_str", 32'(evo), 32'(4'b0100));
        check("t1_pre", 32'(sts_st), 32'(ST_PRE));
        step(2);
        check("t1_pre3", 32'(sts_st), 32'(ST_PRE));
        step(1);
        check("t1_arm", 32'(sts_st), 32'(ST_ARM));
        check("t1_arm_evo", 32'(evo), 32'd0);
        step(4);
        trg = 2'b01;
        step(1);
        trg = 2'b00;
        check("t1_swt", 32'(evo), 32'(4'b0001));
        check("t1_post", 32'(sts_st), 32'(ST_POST));
        step(1);
        check("t1_post2", 32'(evo), 32'd0);
        step(1);
        check("t1_stp", 32'(evo), 32'(4'b0010));
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_idle", 32'(sts_st), 32'(ST_IDLE));
        check("t1_cnt", 32'(sts_rpt), 32'd1);
        step(2);

        // three acquisitions, trigger held; mid-run cfg change must not matter
        exp_q.push_back(EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_IRQ);
        trg = 2'b01;
        start(4'd2, 4'd2, 4'd3, 4'd0, 2'b01);
        cfg_rpt = 4'd1;
        cfg_pst = 4'd9;
        n_bb = 0;
        n = 0;
        while (!irq && n < 60) begin
            step(1);
            n++;
            if (evo.stp && evo.str) n_bb++;
        end
        trg = 2'b00;
        check("t2_irq", 32'(irq), 32'd1);
        check("t2_bb", 32'(n_bb), 32'd2);
        check("t2_cnt", 32'(sts_rpt), 32'd3);
        check("t2_idle", 32'(sts_st), 32'(ST_IDLE));
        step(3);

        // endless run stopped from ARM
        exp_q.push_back(EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_STR);
        exp_q.push_back(EV_STP);
        trg = 2'b01;
        start(4'd1, 4'd1, 4'd0, 4'd0, 2'b01);
        wait_stp(2, 40, "t3_run");
        trg = 2'b00;
        wait_st(ST_ARM, 10, "t3_arm");
        pulse_stp();
        check("t3_stp", 32'(evo), 32'(4'b0010));
        check("t3_idle", 32'(sts_st), 32'(ST_IDLE));
        check("t3_noirq", 32'(irq), 32'd0);
        check("t3_cnt", 32'(sts_rpt), 32'd2);
        step(2);

        // all three controls at once during POST
        exp_q.push_back(EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_STR);
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_RST);
        trg = 2'b01;
        start(4'd1, 4'd3, 4'd0, 4'd0, 2'b01);
        wait_stp(1, 20, "t4_run");
        wait_st(ST_POST, 10, "t4_post");
        check("t4_cnt_pre", 32'(sts_rpt), 32'd1);
        trg = 2'b00;
        ctl_rst = 1'b1; ctl_stp = 1'b1; ctl_str = 1'b1;
        step(1);
        ctl_rst = 1'b0; ctl_stp = 1'b0; ctl_str = 1'b0;
        check("t4_evo", 32'(evo), 32'(4'b1000));
        check("t4_idle", 32'(sts_st), 32'(ST_IDLE));
        check("t4_cnt", 32'(sts_rpt), 32'd0);
        check("t4_noirq", 32'(irq), 32'd0);
        step(2);

        // trigger held through PRE=4, then PRE=0 behaving as 1
        exp_q.push_back(EV_STR); exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_IRQ);
        trg = 2'b01;
        start(4'd4, 4'd1, 4'd1, 4'd0, 2'b01);
        check("t5_str", 32'(evo), 32'(4'b0100));
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t5_pre_evo", 32'(evo), 32'd0);
            check("t5_pre_st", 32'(sts_st), 32'(ST_PRE));
        end
        step(1);
        check("t5_arm", 32'(sts_st), 32'(ST_ARM));
        check("t5_arm_evo", 32'(evo), 32'd0);
        step(1);
        check("t5_swt", 32'(evo), 32'(4'b0001));
        step(1);
        check("t5_stp", 32'(evo), 32'(4'b0010));
        step(2);
        exp_q.push_back(EV_STR); exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_IRQ);
        start(4'd0, 4'd1, 4'd1, 4'd0, 2'b01);
        step(1);
        check("t5z_arm", 32'(sts_st), 32'(ST_ARM));
        step(1);
        check("t5z_swt", 32'(evo), 32'(4'b0001));
        step(1);
        check("t5z_idle", 32'(sts_st), 32'(ST_IDLE));
        trg = 2'b00;
        step(2);

        // arm timeout with only a masked trigger active
        exp_q.push_back(EV_STR);
        trg = 2'b10;
        start(4'd1, 4'd1, 4'd1, 4'd10, 2'b01);
        wait_st(ST_ARM, 5, "t6_arm");
`ifdef EVN_SEQ_TIMEOUT_EN
        exp_q.push_back(EV_SWT); exp_q.push_back(EV_STP | EV_IRQ);
        step(9);
        check("t6_arm10", 32'(sts_st), 32'(ST_ARM));
        check("t6_flag0", 32'(sts_tmo), 32'd0);
        step(1);
        check("t6_swt", 32'(evo), 32'(4'b0001));
        check("t6_flag", 32'(sts_tmo), 32'd1);
        step(1);
        check("t6_idle", 32'(sts_st), 32'(ST_IDLE));
        check("t6_sticky", 32'(sts_tmo), 32'd1);
`else
        exp_q.push_back(EV_STP);
        step(30);
        check("t6_hold", 32'(sts_st), 32'(ST_ARM));
        check("t6_flag", 32'(sts_tmo), 32'd0);
        pulse_stp();
        check("t6_idle", 32'(sts_st), 32'(ST_IDLE));
`endif
        trg = 2'b00;
        step(2);

        // repeat counter saturation at 2^CW-1
        exp_q.push_back(EV_STR);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(EV_SWT);
            exp_q.push_back(EV_STP | EV_STR);
        end
        exp_q.push_back(EV_STP);
        trg = 2'b01;
        start(4'd1, 4'd1, 4'd0, 4'd0, 2'b01);
        wait_stp(17, 200, "t7_run");
        check("t7_sat", 32'(sts_rpt), 32'd15);
        trg = 2'b00;
        pulse_stp();
        check("t7_idle", 32'(sts_st), 32'(ST_IDLE));
        check("t7_hold", 32'(sts_rpt), 32'd15);
        step(2);

        // asynchronous reset mid-sequence
        exp_q.push_back(EV_STR);
        start(4'd5, 4'd1, 4'd2, 4'd0, 2'b01);
        step(1);
        #2 rst = 1'b1;
        #1;
        check("t8_st", 32'(sts_st), 32'(ST_IDLE));
        check("t8_evo", 32'(evo), 32'd0);
        check("t8_cnt", 32'(sts_rpt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(5);
        check("t8_stay", 32'(sts_st), 32'(ST_IDLE));

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
